// File: rtl/aes_defs.sv
// Shared AES definitions: round count, FSM encodings, inverse S-box table,
// and the GF(2^8) helpers used by the inverse cipher datapath.
package aes_defs;

   localparam int NR = 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_FINAL = 2'd2
   } state_t;

   // Inverse S-box, entry 0 in the most significant byte.
   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul9(input logic [7:0] b);
      logic [7:0] x2, x4, x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ b;
   endfunction

   function automatic logic [7:0] gf_mulb(input logic [7:0] b);
      logic [7:0] x2, x4, x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ x2 ^ b;
   endfunction

   function automatic logic [7:0] gf_muld(input logic [7:0] b);
      logic [7:0] x2, x4, x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ x4 ^ b;
   endfunction

   function automatic logic [7:0] gf_mule(input logic [7:0] b);
      logic [7:0] x2, x4, x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ x4 ^ x2;
   endfunction

   // Row r rotates right by r columns; byte index is row + 4*column.
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] res;
      res = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            res[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
         end
      end
      return res;
   endfunction

   function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3),
              gf_mul9(a0) ^ gf_mule(a1) ^ gf_mulb(a2) ^ gf_muld(a3),
              gf_muld(a0) ^ gf_mul9(a1) ^ gf_mule(a2) ^ gf_mulb(a3),
              gf_mulb(a0) ^ gf_muld(a1) ^ gf_mul9(a2) ^ gf_mule(a3)};
   endfunction

endpackage

// File: rtl/engine_inv_sbox.sv
// Single-byte inverse S-box lookup, purely combinational.
module engine_inv_sbox
   import aes_defs::*;
(
   input  logic [7:0] i_byte,
   output logic [7:0] o_byte
);

   // Table is stored entry 0 first, so index from the top using ~i_byte.
   assign o_byte = INV_SBOX[{~i_byte, 3'b000} +: 8];

endmodule

// File: rtl/engine_inverse_round_transformer.sv
// Iterative AES-128 inverse cipher: one round per clock, done pulse on completion.
module engine_inverse_round_transformer
   import aes_defs::*;
(
   input  logic         clk,
   input  logic         rst_,
   input  logic         transformer_start,
   input  logic [127:0] ciphertext,
   input  logic [127:0] round0_key,
   input  logic [127:0] round1_key,
   input  logic [127:0] round2_key,
   input  logic [127:0] round3_key,
   input  logic [127:0] round4_key,
   input  logic [127:0] round5_key,
   input  logic [127:0] round6_key,
   input  logic [127:0] round7_key,
   input  logic [127:0] round8_key,
   input  logic [127:0] round9_key,
   input  logic [127:0] round10_key,
   output logic [127:0] plaintext,
   output logic         transformer_done
);

   state_t       r_state;
   logic [3:0]   r_ctr;
   logic [127:0] r_data;
   logic [127:0] r_plain;
   logic         r_done;

   state_t       w_state_nx;
   logic [3:0]   w_ctr_nx;
   logic [127:0] w_data_nx;
   logic [127:0] w_plain_nx;
   logic         w_done_nx;

   logic [127:0] w_isr;
   logic [127:0] w_isb;
   logic [127:0] w_key;
   logic [127:0] w_ark;
   logic [127:0] w_imc;

   assign w_isr = inv_shift_rows(r_data);

   for (genvar g = 0; g < 16; g++) begin : g_isb
      engine_inv_sbox u_isb (
         .i_byte(w_isr[8*g +: 8]),
         .o_byte(w_isb[8*g +: 8])
      );
   end

   // Middle-round key chosen by the down-counter.
   always_comb begin
      w_key = '0;
      case (r_ctr)
         4'd1:    w_key = round1_key;
         4'd2:    w_key = round2_key;
         4'd3:    w_key = round3_key;
         4'd4:    w_key = round4_key;
         4'd5:    w_key = round5_key;
         4'd6:    w_key = round6_key;
         4'd7:    w_key = round7_key;
         4'd8:    w_key = round8_key;
         4'd9:    w_key = round9_key;
         default: w_key = '0;
      endcase
   end

   assign w_ark = w_isb ^ w_key;

   for (genvar g = 0; g < 4; g++) begin : g_imc
      assign w_imc[32*g +: 32] = inv_mix_column(w_ark[32*g +: 32]);
   end

   // Next-state and datapath update selection; done is low unless finishing.
   always_comb begin
      w_state_nx = r_state;
      w_ctr_nx   = r_ctr;
      w_data_nx  = r_data;
      w_plain_nx = r_plain;
      w_done_nx  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (transformer_start) begin
               w_data_nx  = ciphertext ^ round10_key;
               w_ctr_nx   = 4'(NR - 1);
               w_state_nx = ST_ROUND;
            end
         end
         ST_ROUND: begin
            w_data_nx = w_imc;
            w_ctr_nx  = r_ctr - 4'd1;
            if (r_ctr == 4'd1) begin
               w_state_nx = ST_FINAL;
            end
         end
         ST_FINAL: begin
            w_plain_nx = w_isb ^ round0_key;
            w_done_nx  = 1'b1;
            w_state_nx = ST_IDLE;
         end
         default: begin
            w_state_nx = ST_IDLE;
         end
      endcase
   end

   // State, counter, round state and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst_) begin
         r_state <= ST_IDLE;
         r_ctr   <= '0;
         r_data  <= '0;
         r_plain <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_ctr   <= w_ctr_nx;
         r_data  <= w_data_nx;
         r_plain <= w_plain_nx;
         r_done  <= w_done_nx;
      end
   end

   assign plaintext        = r_plain;
   assign transformer_done = r_done;

endmodule

// File: tb/tb_engine_inverse_round_transformer.sv
// Directed bench for the AES-128 inverse round transformer using FIPS-197 vectors.
module tb_engine_inverse_round_transformer;

   logic         clk;
   logic         rst_;
   logic         transformer_start;
   logic [127:0] ciphertext;
   logic [127:0] rk [0:10];
   logic [127:0] plaintext;
   logic         transformer_done;

   int errs;
   int checks;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

   engine_inverse_round_transformer dut (
      .clk              (clk),
      .rst_             (rst_),
      .transformer_start(transformer_start),
      .ciphertext       (ciphertext),
      .round0_key       (rk[0]),
      .round1_key       (rk[1]),
      .round2_key       (rk[2]),
      .round3_key       (rk[3]),
      .round4_key       (rk[4]),
      .round5_key       (rk[5]),
      .round6_key       (rk[6]),
      .round7_key       (rk[7]),
      .round8_key       (rk[8]),
      .round9_key       (rk[9]),
      .round10_key      (rk[10]),
      .plaintext        (plaintext),
      .transformer_done (transformer_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Generic shift-and-add GF(2^8) multiply.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Forward S-box from multiplicative inverse plus affine map.
   function automatic logic [7:0] fwd_sbox(input logic [7:0] v);
      logic [7:0] inv;
      logic [7:0] s;
      inv = 8'h00;
      if (v != 8'h00) begin
         inv = 8'h01;
         for (int i = 0; i < 254; i++) inv = gmul(inv, v);
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      return s;
   endfunction

   task automatic expand_key(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rcon;
      rcon = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {fwd_sbox(t[31:24]) ^ rcon, fwd_sbox(t[23:16]),
                 fwd_sbox(t[15:8]), fwd_sbox(t[7:0])};
            rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int k = 0; k < 11; k++) rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts a block at the next edge and checks the full latency window.
   // Returns positioned in the done cycle.
   task automatic run_block(input string tag, input logic [127:0] ct,
                            input logic [127:0] exp_pt, input logic [127:0] hold_pt,
                            input bit keep_start);
      transformer_start = 1'b1;
      ciphertext        = ct;
      tick();
      if (keep_start) ciphertext = ~ct;
      else            transformer_start = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         tick();
         check({tag, "_busy_done"}, {127'd0, transformer_done}, 128'd0);
         check({tag, "_hold_pt"}, plaintext, hold_pt);
      end
      tick();
      check({tag, "_done"}, {127'd0, transformer_done}, 128'd1);
      check({tag, "_pt"}, plaintext, exp_pt);
   endtask

   initial begin
      errs              = 0;
      checks            = 0;
      rst_              = 1'b1;
      transformer_start = 1'b0;
      ciphertext        = '0;
      for (int k = 0; k < 11; k++) rk[k] = '0;

      tick();
      tick();
      check("reset_pt", plaintext, 128'd0);
      check("reset_done", {127'd0, transformer_done}, 128'd0);
      rst_ = 1'b0;
      tick();

      expand_key(C1_KEY);
      run_block("c1", C1_CT, C1_PT, 128'd0, 1'b0);
      tick();
      check("c1_pulse_width", {127'd0, transformer_done}, 128'd0);
      check("c1_pt_holds", plaintext, C1_PT);

      expand_key(B_KEY);
      run_block("appb", B_CT, B_PT, C1_PT, 1'b0);
      tick();
      check("appb_pulse_width", {127'd0, transformer_done}, 128'd0);

      expand_key(C1_KEY);
      run_block("b2b_first", C1_CT, C1_PT, B_PT, 1'b0);
      expand_key(B_KEY);
      run_block("b2b_second", B_CT, B_PT, C1_PT, 1'b0);
      tick();
      check("b2b_pulse_width", {127'd0, transformer_done}, 128'd0);

      expand_key(C1_KEY);
      run_block("held_first", C1_CT, C1_PT, B_PT, 1'b1);
      run_block("held_second", C1_CT, C1_PT, C1_PT, 1'b1);
      transformer_start = 1'b0;
      tick();
      check("held_end_done", {127'd0, transformer_done}, 128'd0);

      tick();
      transformer_start = 1'b1;
      ciphertext        = C1_CT;
      tick();
      transformer_start = 1'b0;
      for (int i = 1; i <= 4; i++) tick();
      rst_ = 1'b1;
      tick();
      rst_ = 1'b0;
      check("abort_pt", plaintext, 128'd0);
      for (int i = 0; i < 12; i++) begin
         check("abort_no_done", {127'd0, transformer_done}, 128'd0);
         tick();
      end
      run_block("after_abort", C1_CT, C1_PT, 128'd0, 1'b0);
      tick();

      rst_              = 1'b1;
      transformer_start = 1'b1;
      ciphertext        = C1_CT;
      tick();
      rst_              = 1'b0;
      transformer_start = 1'b0;
      check("rst_start_pt", plaintext, 128'd0);
      for (int i = 0; i < 12; i++) begin
         tick();
         check("rst_start_no_done", {127'd0, transformer_done}, 128'd0);
      end
      check("rst_start_pt_end", plaintext, 128'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
